round_counter: RTL and testbench

ROUND_COUNTER -- requirements
Module: round_counter

---
 rtl/round_cnt_pkg.sv | 26 ++
 rtl/round_cnt_ch.sv | 133 +++++++++++++
 rtl/round_counter.sv | 63 ++++++
 tb/tb_round_counter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/round_cnt_pkg.sv
// ---------------------------------------------------------------------------
// round_cnt_pkg
// Shared definitions for the round_counter block: the per-channel FSM state
// type and the default parameter values used by round_counter / round_cnt_ch.
//
// Optional feature macro (used by round_cnt_ch): ROUND_SUM_SAT_EN
//   defined   -> cumulative step total saturates at all-ones
//   undefined -> cumulative step total wraps modulo 2^SUM_W
// ---------------------------------------------------------------------------
package round_cnt_pkg;

    // Per-channel session state.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } round_state_e;

    // Default configuration.
    localparam int unsigned DEF_NCH       = 2;
    localparam int unsigned DEF_CNT_W     = 6;
    localparam int unsigned DEF_SUM_W     = 10;
    localparam int unsigned DEF_RND_W     = 6;
    localparam int unsigned DEF_RND_LIMIT = 4;

endpackage : round_cnt_pkg

// File: rtl/round_cnt_ch.sv
// ---------------------------------------------------------------------------
// round_cnt_ch
// One independent counting channel. Counts steps 0..max_num per round; each
// round completion (wrap) bumps the round counter. After RND_LIMIT rounds the
// channel parks in DONE until cleared by control/judge.
//
// Ports
//   clk_i      : clock, rising edge
//   rst_i      : asynchronous active-high reset
//   control_i  : session enable; low clears everything incl. the step total
//   judge_i    : channel enable; low restarts the round (step total held)
//   max_num_i  : steps per round
//   now_num_o  : current step count within the round
//   sum_num_o  : cumulative steps taken in the session
//   flag_o     : completed rounds
//   done_o     : registered, high exactly while in DONE
//
// Macro ROUND_SUM_SAT_EN: when defined, sum_num_o saturates at all-ones;
// otherwise it wraps.
// ---------------------------------------------------------------------------
module round_cnt_ch
    import round_cnt_pkg::*;
#(
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned SUM_W     = DEF_SUM_W,
    parameter int unsigned RND_W     = DEF_RND_W,
    parameter int unsigned RND_LIMIT = DEF_RND_LIMIT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             control_i,
    input  logic             judge_i,
    input  logic [CNT_W-1:0] max_num_i,
    output logic [CNT_W-1:0] now_num_o,
    output logic [SUM_W-1:0] sum_num_o,
    output logic [RND_W-1:0] flag_o,
    output logic             done_o
);

    localparam logic [RND_W-1:0] LIMIT = RND_W'(RND_LIMIT);

    round_state_e     state_q, state_d;
    logic [CNT_W-1:0] now_q,   now_d;
    logic [SUM_W-1:0] sum_q,   sum_d;
    logic [RND_W-1:0] flag_q,  flag_d;
    logic             done_q,  done_d;

    logic [RND_W-1:0] flag_inc;
    logic [SUM_W-1:0] sum_inc;

    assign flag_inc = flag_q + RND_W'(1);

`ifdef ROUND_SUM_SAT_EN
    // Hold at all-ones instead of rolling over.
    assign sum_inc = (sum_q == '1) ? sum_q : sum_q + SUM_W'(1);
`else
    assign sum_inc = sum_q + SUM_W'(1);
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            now_q   <= '0;
            sum_q   <= '0;
            flag_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            now_q   <= now_d;
            sum_q   <= sum_d;
            flag_q  <= flag_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        now_d   = now_q;
        sum_d   = sum_q;
        flag_d  = flag_q;

        if (!control_i) begin
            // Session clear wins over everything else.
            state_d = IDLE;
            now_d   = '0;
            sum_d   = '0;
            flag_d  = '0;
        end else if (!judge_i) begin
            // Round restart: the session step total survives.
            state_d = IDLE;
            now_d   = '0;
            flag_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // Arm only; first step is taken on the following edge.
                    state_d = COUNT;
                end
                COUNT: begin
                    if (now_q < max_num_i) begin
                        now_d = now_q + CNT_W'(1);
                        sum_d = sum_inc;
                    end else begin
                        // Covers max_num lowered below now_num mid-round too.
                        now_d  = '0;
                        flag_d = flag_inc;
                        if (flag_inc == LIMIT) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    now_d  = '0;
                    flag_d = LIMIT;
                end
                default: begin
                    state_d = IDLE;
                    now_d   = '0;
                    flag_d  = '0;
                end
            endcase
        end

        // done is registered: it reflects the state being entered.
        done_d = (state_d == DONE);
    end

    assign now_num_o = now_q;
    assign sum_num_o = sum_q;
    assign flag_o    = flag_q;
    assign done_o    = done_q;

endmodule : round_cnt_ch

// File: rtl/round_counter.sv
// ---------------------------------------------------------------------------
// round_counter
// NCH independent round counters sharing a session enable (control) and a
// steps-per-round limit (max_num). Each channel has its own enable (judge).
//
// Ports
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   control  : session enable; low synchronously clears all channels
//   judge    : [NCH] per-channel enable; low restarts that channel's round
//   max_num  : [CNT_W] steps per round, shared
//   now_num  : [NCH*CNT_W] step counts, channel i at [i*CNT_W +: CNT_W]
//   sum_num  : [NCH*SUM_W] cumulative step totals, same packing
//   flag     : [NCH*RND_W] completed rounds, same packing
//   done     : [NCH] per-channel session complete (registered)
//   all_done : AND of all done bits
//
// Macro ROUND_SUM_SAT_EN: when defined, sum_num saturates per channel;
// otherwise it wraps modulo 2^SUM_W.
// ---------------------------------------------------------------------------
module round_counter
    import round_cnt_pkg::*;
#(
    parameter int unsigned NCH       = DEF_NCH,
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned SUM_W     = DEF_SUM_W,
    parameter int unsigned RND_W     = DEF_RND_W,
    parameter int unsigned RND_LIMIT = DEF_RND_LIMIT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 control,
    input  logic [NCH-1:0]       judge,
    input  logic [CNT_W-1:0]     max_num,
    output logic [NCH*CNT_W-1:0] now_num,
    output logic [NCH*SUM_W-1:0] sum_num,
    output logic [NCH*RND_W-1:0] flag,
    output logic [NCH-1:0]       done,
    output logic                 all_done
);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        round_cnt_ch #(
            .CNT_W     (CNT_W),
            .SUM_W     (SUM_W),
            .RND_W     (RND_W),
            .RND_LIMIT (RND_LIMIT)
        ) u_ch (
            .clk_i     (clk),
            .rst_i     (rst),
            .control_i (control),
            .judge_i   (judge[i]),
            .max_num_i (max_num),
            .now_num_o (now_num[i*CNT_W +: CNT_W]),
            .sum_num_o (sum_num[i*SUM_W +: SUM_W]),
            .flag_o    (flag[i*RND_W +: RND_W]),
            .done_o    (done[i])
        );
    end

    assign all_done = &done;

endmodule : round_counter

// File: tb/tb_round_counter.sv
// ---------------------------------------------------------------------------
// tb_round_counter
// Two instances: a default-configured 2-channel counter and a 1-channel
// counter with a 4-bit step total (exercises saturation / wrap of sum_num).
// Both are compared every edge against a behavioural model of the rules.
// ---------------------------------------------------------------------------
module tb_round_counter;

    localparam int NCH   = 2;
    localparam int CNT_W = 6;
    localparam int SUM_W = 10;
    localparam int RND_W = 6;
    localparam int LIM   = 4;
    localparam int SUM_WS = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 control;
    logic [NCH-1:0]       judge;
    logic [CNT_W-1:0]     max_num;
    logic [NCH*CNT_W-1:0] now_num;
    logic [NCH*SUM_W-1:0] sum_num;
    logic [NCH*RND_W-1:0] flag;
    logic [NCH-1:0]       done;
    logic                 all_done;

    logic [CNT_W-1:0]  now_s;
    logic [SUM_WS-1:0] sum_s;
    logic [RND_W-1:0]  flag_s;
    logic [0:0]        done_s;
    logic              all_done_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    round_counter #(
        .NCH (NCH), .CNT_W (CNT_W), .SUM_W (SUM_W), .RND_W (RND_W), .RND_LIMIT (LIM)
    ) dut (
        .clk (clk), .rst (rst), .control (control), .judge (judge),
        .max_num (max_num), .now_num (now_num), .sum_num (sum_num),
        .flag (flag), .done (done), .all_done (all_done)
    );

    round_counter #(
        .NCH (1), .CNT_W (CNT_W), .SUM_W (SUM_WS), .RND_W (RND_W), .RND_LIMIT (LIM)
    ) dut_s (
        .clk (clk), .rst (rst), .control (control), .judge (judge[0]),
        .max_num (max_num), .now_num (now_s), .sum_num (sum_s),
        .flag (flag_s), .done (done_s), .all_done (all_done_s)
    );

    // Model: index 0,1 = dut channels; index 2 = dut_s channel (follows judge[0]).
    int  m_step  [3];
    int  m_round [3];
    int  m_total [3];
    bit  m_armed [3];
    bit  m_fin   [3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            m_step[c] = 0; m_round[c] = 0; m_total[c] = 0;
            m_armed[c] = 0; m_fin[c] = 0;
        end
    endtask

    task automatic model_edge();
        for (int c = 0; c < 3; c++) begin
            bit j;
            int mask;
            j    = (c < 2) ? judge[c] : judge[0];
            mask = (c < 2) ? (1 << SUM_W) - 1 : (1 << SUM_WS) - 1;
            if (!control) begin
                m_step[c] = 0; m_round[c] = 0; m_total[c] = 0;
                m_armed[c] = 0; m_fin[c] = 0;
            end else if (!j) begin
                m_step[c] = 0; m_round[c] = 0; m_armed[c] = 0; m_fin[c] = 0;
            end else if (!m_armed[c]) begin
                m_armed[c] = 1;
            end else if (!m_fin[c]) begin
                if (m_step[c] < int'(max_num)) begin
                    m_step[c]++;
`ifdef ROUND_SUM_SAT_EN
                    if (m_total[c] < mask) m_total[c]++;
`else
                    m_total[c] = (m_total[c] + 1) & mask;
`endif
                end else begin
                    m_step[c] = 0;
                    m_round[c]++;
                    if (m_round[c] == LIM) m_fin[c] = 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        bit all_fin;
        all_fin = 1;
        for (int c = 0; c < NCH; c++) begin
            check($sformatf("now%0d", c),  32'(now_num[c*CNT_W +: CNT_W]), 32'(m_step[c]));
            check($sformatf("sum%0d", c),  32'(sum_num[c*SUM_W +: SUM_W]), 32'(m_total[c]));
            check($sformatf("flag%0d", c), 32'(flag[c*RND_W +: RND_W]),    32'(m_round[c]));
            check($sformatf("done%0d", c), 32'(done[c]),                  32'(m_fin[c]));
            all_fin &= m_fin[c];
        end
        check("all_done", 32'(all_done), 32'(all_fin));
        check("s_now",  32'(now_s),  32'(m_step[2]));
        check("s_sum",  32'(sum_s),  32'(m_total[2]));
        check("s_flag", 32'(flag_s), 32'(m_round[2]));
        check("s_done", 32'(done_s), 32'(m_fin[2]));
        check("s_all_done", 32'(all_done_s), 32'(m_fin[2]));
    endtask

    // Inputs are changed only at posedge+1; model sees the values present at the edge.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge();
            #1;
            compare_all();
        end
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        check("rst_now0", 32'(now_num[0 +: CNT_W]), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; control = 1'b0; judge = '0; max_num = '0;
        model_reset();
        #12;
        compare_all();
        rst = 1'b0;
        step(1);

        // Full session, max_num=3: done after edge 17, stable to edge 20.
        control = 1'b1; judge = 2'b11; max_num = 6'd3;
        step(17);
        check("s17_flag0", 32'(flag[0 +: RND_W]),     32'd4);
        check("s17_sum1",  32'(sum_num[SUM_W +: SUM_W]), 32'd12);
        check("s17_alldone", 32'(all_done), 32'd1);
        step(3);
        check("s20_done", 32'(done), 32'd3);

        // Clear from DONE.
        control = 1'b0;
        step(1);
        check("clr_done", 32'(done), 32'd0);
        check("clr_sum1", 32'(sum_num[SUM_W +: SUM_W]), 32'd0);

        // Round restart on channel 0 mid-round (now=2, flag=1).
        control = 1'b1; judge = 2'b11; max_num = 6'd3;
        step(7);
        check("pre_now0",  32'(now_num[0 +: CNT_W]), 32'd2);
        check("pre_flag0", 32'(flag[0 +: RND_W]),    32'd1);
        judge = 2'b10;
        step(1);
        check("rr_now0", 32'(now_num[0 +: CNT_W]), 32'd0);
        check("rr_sum0", 32'(sum_num[0 +: SUM_W]), 32'd5);
        check("rr_now1", 32'(now_num[CNT_W +: CNT_W]), 32'd3);
        judge = 2'b11;
        step(4);

        // max_num=0: a wrap every COUNT edge.
        control = 1'b0; step(1);
        control = 1'b1; max_num = 6'd0;
        step(5);
        check("z_done", 32'(done), 32'd3);
        check("z_sum0", 32'(sum_num[0 +: SUM_W]), 32'd0);

        // Lower max_num below now_num mid-round.
        control = 1'b0; step(1);
        control = 1'b1; max_num = 6'd5;
        step(4);
        check("dec_pre", 32'(now_num[0 +: CNT_W]), 32'd3);
        max_num = 6'd1;
        step(1);
        check("dec_now", 32'(now_num[0 +: CNT_W]), 32'd0);
        check("dec_flag", 32'(flag[0 +: RND_W]), 32'd1);

        // Async reset mid-COUNT with now=3.
        control = 1'b0; step(1);
        control = 1'b1; max_num = 6'd5;
        step(4);
        async_reset();
        step(2);

        // 4-bit total: 28 increments over a session with max_num=7.
        control = 1'b0; step(1);
        control = 1'b1; max_num = 6'd7;
        step(33);
`ifdef ROUND_SUM_SAT_EN
        check("sw_sum", 32'(sum_s), 32'd15);
`else
        check("sw_sum", 32'(sum_s), 32'd12);
`endif

        // Randomized traffic.
        for (int it = 0; it < 600; it++) begin
            control = ($urandom_range(0, 39) != 0);
            for (int c = 0; c < NCH; c++) judge[c] = ($urandom_range(0, 29) != 0);
            if ($urandom_range(0, 9) == 0) max_num = 6'($urandom_range(0, 4));
            if ($urandom_range(0, 99) == 0) async_reset();
            else step(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL timeout: got no finish expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule : tb_round_counter
